// File: rtl/resp_defs.sv
// rtl/resp_defs.sv - shared type codes, ASCII constants and state encodings for the response encoder
//
// Purpose: common definitions imported by uart_resp_encoder and bin2dec_seq.
// Ports: none (package).
package resp_defs;

  typedef enum logic [1:0] {
    RESP_OK  = 2'd0,
    RESP_ERR = 2'd1,
    RESP_VAL = 2'd2,
    RESP_RSV = 2'd3
  } resp_type_t;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_O     = 8'h4F;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_Q     = 8'h3F;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO
  } resp_state_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_HUND,
    CV_TENS
  } conv_state_t;

  // Negative VAL payloads are negated in 9 bits so that -128 yields 128.
  function automatic logic [8:0] resp_magnitude(input resp_type_t t, input logic [7:0] v);
    if (t == RESP_VAL && v[7]) return 9'd0 - {1'b1, v};
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/uart_resp_encoder_bin2dec.sv
// rtl/uart_resp_encoder_bin2dec.sv - sequential binary to decimal digit converter
//
// Purpose: splits a 9-bit value into hundreds/tens/units with one subtraction per cycle.
// Ports: clk, rst_n (sync, active-low); start loads bin; done pulses (combinational)
//        in the cycle the digits become valid; hundreds/tens/units hold until next start.
module bin2dec_seq
  import resp_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  conv_state_t phase;
  logic [8:0]  rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= CV_IDLE;
      rem      <= '0;
      hundreds <= '0;
      tens     <= '0;
    end else if (start) begin
      phase    <= CV_HUND;
      rem      <= bin;
      hundreds <= '0;
      tens     <= '0;
    end else begin
      case (phase)
        CV_HUND: begin
          if (rem >= 9'd100) begin
            rem      <= rem - 9'd100;
            hundreds <= hundreds + 4'd1;
          end else begin
            phase <= CV_TENS;
          end
        end
        CV_TENS: begin
          if (rem >= 9'd10) begin
            rem  <= rem - 9'd10;
            tens <= tens + 4'd1;
          end else begin
            phase <= CV_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // The final tens cycle already holds the remainder below ten, so done is
  // raised there rather than a cycle later.
  assign done  = (phase == CV_TENS) && (rem < 9'd10);
  assign units = rem[3:0];

endmodule

// File: rtl/uart_resp_encoder.sv
// rtl/uart_resp_encoder.sv - serialises OK/ERR/VAL responses as ASCII lines into a UART transmitter
//
// Purpose: accepts short response requests and emits one text line per request,
//          byte by byte, through the transmitter start/busy handshake.
// Ports: clk, rst_n (sync, active-low); req_valid/req_type/req_value/req_ready request side;
//        tx_data/tx_valid/tx_busy transmitter side; resp_busy line in progress or queued;
//        drop_flag pulses for each request offered while not ready.
// Config: RESP_FIFO_EN adds a 4-entry request queue in front of the sequencer.
module uart_resp_encoder
  import resp_defs::*;
#(
  parameter int EOL_CRLF  = 1,
  parameter int ACK_GUARD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_type,
  input  logic [7:0] req_value,
  output logic       req_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  output logic       resp_busy,
  output logic       drop_flag
);

  localparam logic [7:0] GUARD_LIM = 8'(ACK_GUARD - 1);
  localparam logic [3:0] EOL_LEN   = (EOL_CRLF != 0) ? 4'd2 : 4'd1;

  resp_state_t state, state_nx;
  resp_type_t  typ_q, take_type;
  logic [7:0]  take_value;
  logic        take, q_empty;
  logic        neg_q, last_q, dig_ok_q;
  logic [3:0]  idx_q;
  logic [7:0]  data_q, guard_q;

`ifdef RESP_FIFO_EN
  logic [9:0] q_mem [4];
  logic [1:0] q_wp, q_rp;
  logic [2:0] q_cnt;
  logic       q_push;

  assign req_ready  = (q_cnt != 3'd4);
  assign q_push     = req_valid && req_ready;
  assign q_empty    = (q_cnt == 3'd0);
  assign take       = (state == ST_IDLE) && !q_empty;
  assign take_type  = resp_type_t'(q_mem[q_rp][9:8]);
  assign take_value = q_mem[q_rp][7:0];

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wp] <= {req_type, req_value};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) q_wp <= q_wp + 2'd1;
      if (take)   q_rp <= q_rp + 2'd1;
      case ({q_push, take})
        2'b10:   q_cnt <= q_cnt + 3'd1;
        2'b01:   q_cnt <= q_cnt - 3'd1;
        default: ;
      endcase
    end
  end
`else
  assign req_ready  = (state == ST_IDLE);
  assign q_empty    = 1'b1;
  assign take       = req_valid && req_ready;
  assign take_type  = resp_type_t'(req_type);
  assign take_value = req_value;
`endif

  logic       conv_start, conv_done, dig_ready;
  logic [8:0] take_mag;
  logic [3:0] hun, ten, uni;

  assign take_mag   = resp_magnitude(take_type, take_value);
  assign conv_start = take && (take_type == RESP_ERR || take_type == RESP_VAL);
  assign dig_ready  = dig_ok_q || conv_done;

  bin2dec_seq u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (conv_start),
    .bin      (take_mag),
    .done     (conv_done),
    .hundreds (hun),
    .tens     (ten),
    .units    (uni)
  );

  // Byte sequencer: index walks prefix, then significant digits, then EOL.
  logic       has_dig, cur_avail, cur_last;
  logic [3:0] pre_len, ndig, d, e, k, dig;
  logic [7:0] cur_byte;

  always_comb begin
    has_dig   = (typ_q == RESP_ERR) || (typ_q == RESP_VAL);
    cur_byte  = ASC_0;
    cur_avail = 1'b1;
    cur_last  = 1'b0;
    dig       = uni;
    case (typ_q)
      RESP_OK:  pre_len = 4'd2;
      RESP_ERR: pre_len = 4'd4;
      RESP_VAL: pre_len = neg_q ? 4'd1 : 4'd0;
      default:  pre_len = 4'd1;
    endcase
    if (!has_dig)         ndig = 4'd0;
    else if (hun != 4'd0) ndig = 4'd3;
    else if (ten != 4'd0) ndig = 4'd2;
    else                  ndig = 4'd1;
    d = idx_q - pre_len;
    e = d - ndig;
    k = ndig - 4'd1 - d;
    if (idx_q < pre_len) begin
      case (typ_q)
        RESP_OK:  cur_byte = (idx_q == 4'd0) ? ASC_O : ASC_K;
        RESP_ERR: cur_byte = (idx_q == 4'd0) ? ASC_E : (idx_q == 4'd3) ? ASC_SP : ASC_R;
        RESP_VAL: cur_byte = ASC_MINUS;
        default:  cur_byte = ASC_Q;
      endcase
    end else if (has_dig && !dig_ready) begin
      cur_avail = 1'b0;
    end else if (d < ndig) begin
      case (k)
        4'd2:    dig = hun;
        4'd1:    dig = ten;
        default: dig = uni;
      endcase
      cur_byte = ASC_0 + {4'd0, dig};
    end else begin
      cur_byte = (e == 4'd0 && EOL_CRLF != 0) ? ASC_CR : ASC_LF;
      cur_last = (e == EOL_LEN - 4'd1);
    end
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    case (state)
      ST_IDLE:    if (take) state_nx = ST_LOAD;
      ST_LOAD:    state_nx = ST_SEND;
      ST_SEND: begin
        if (!tx_busy && cur_avail) begin
          tx_valid = 1'b1;
          state_nx = ST_WAIT_HI;
        end
      end
      // Guard lets the line progress even if the transmitter never acknowledges.
      ST_WAIT_HI: if (tx_busy || guard_q >= GUARD_LIM) state_nx = ST_WAIT_LO;
      ST_WAIT_LO: if (!tx_busy) state_nx = last_q ? ST_IDLE : ST_SEND;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      typ_q    <= RESP_OK;
      neg_q    <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      data_q   <= '0;
      guard_q  <= '0;
      dig_ok_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        typ_q    <= take_type;
        neg_q    <= (take_type == RESP_VAL) && take_value[7];
        idx_q    <= '0;
        dig_ok_q <= 1'b0;
      end else if (conv_done) begin
        dig_ok_q <= 1'b1;
      end
      if (tx_valid) begin
        data_q  <= cur_byte;
        idx_q   <= idx_q + 4'd1;
        last_q  <= cur_last;
        guard_q <= 8'd1;
      end else if (state == ST_WAIT_HI) begin
        guard_q <= guard_q + 8'd1;
      end
    end
  end

  assign tx_data   = tx_valid ? cur_byte : data_q;
  assign resp_busy = (state != ST_IDLE) || !q_empty;
  assign drop_flag = req_valid && !req_ready;

endmodule

// File: tb/tb_uart_resp_encoder.sv
// tb/tb_uart_resp_encoder.sv - randomized self-checking bench for uart_resp_encoder
module tb_uart_resp_encoder;

  localparam int G        = 4;
  localparam int BUSY_LEN = 20;
`ifdef RESP_FIFO_EN
  localparam int FIFO_OFF = 1;
`else
  localparam int FIFO_OFF = 0;
`endif

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_type;
  logic [7:0] req_value;
  logic [1:0] req_ready, tx_valid, tx_busy, resp_busy, drop_flag;
  logic [7:0] tx_data [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int txm      = 0;
  int busy_cnt [2] = '{0, 0};
  int b2b [2]      = '{0, 0};
  logic [1:0] prev_v = 2'b00;

  logic [7:0] cap_d0 [$];
  logic [7:0] cap_d1 [$];
  int         cap_c0 [$];
  int         cap_c1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_resp_encoder #(.EOL_CRLF(1), .ACK_GUARD(G)) u_dut_crlf (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
    .req_value(req_value), .req_ready(req_ready[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_busy(tx_busy[0]), .resp_busy(resp_busy[0]),
    .drop_flag(drop_flag[0])
  );

  uart_resp_encoder #(.EOL_CRLF(0), .ACK_GUARD(G)) u_dut_lf (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
    .req_value(req_value), .req_ready(req_ready[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_busy(tx_busy[1]), .resp_busy(resp_busy[1]),
    .drop_flag(drop_flag[1])
  );

  // Transmitter model: mode 0 raises busy the cycle after a start and holds it
  // BUSY_LEN cycles; mode 1 never raises busy.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_valid[i] && txm == 0) busy_cnt[i] <= BUSY_LEN;
      else if (busy_cnt[i] > 0)    busy_cnt[i] <= busy_cnt[i] - 1;
    end
  end
  assign tx_busy[0] = (busy_cnt[0] > 0);
  assign tx_busy[1] = (busy_cnt[1] > 0);

  always @(negedge clk) begin
    if (tx_valid[0]) begin cap_d0.push_back(tx_data[0]); cap_c0.push_back(cyc); end
    if (tx_valid[1]) begin cap_d1.push_back(tx_data[1]); cap_c1.push_back(cyc); end
    for (int i = 0; i < 2; i++) if (tx_valid[i] && prev_v[i]) b2b[i]++;
    prev_v = tx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t model_line(input logic [1:0] t, input logic [7:0] v, input bit crlf);
    bq_t q;
    string s;
    case (t)
      2'd0:    s = "OK";
      2'd1:    s = $sformatf("ERR %0d", v);
      2'd2:    s = $sformatf("%0d", $signed(v));
      default: s = "?";
    endcase
    s = crlf ? {s, "\r\n"} : {s, "\n"};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic clear_caps();
    cap_d0.delete(); cap_d1.delete(); cap_c0.delete(); cap_c1.delete();
  endtask

  task automatic compare_bytes(input int i, input bq_t exp);
    logic [7:0] d [$];
    int n;
    if (i == 0) d = cap_d0; else d = cap_d1;
    check_eq($sformatf("len%0d", i), d.size(), exp.size());
    n = (d.size() < exp.size()) ? d.size() : exp.size();
    for (int j = 0; j < n; j++) check_eq($sformatf("byte%0d_%0d", i, j), 32'(d[j]), 32'(exp[j]));
  endtask

  // Expected pulse times: 2 cycles after the take, then one transmitter round
  // trip per byte, with the first digit held back until conversion finishes.
  task automatic compare_timing(input int i, input logic [1:0] t, input logic [7:0] v,
                                input int mode, input int acc, input int nbytes);
    int c [$];
    int mag, h, tn, fd, t_exp, gap, ready_t, n;
    if (i == 0) c = cap_c0; else c = cap_c1;
    mag = (t == 2'd2 && v[7]) ? 256 - int'(v) : int'(v);
    h  = mag / 100;
    tn = (mag % 100) / 10;
    fd = (t == 2'd1) ? 4 : (t == 2'd2) ? (v[7] ? 1 : 0) : -1;
    gap = (mode != 0) ? G + 1 : BUSY_LEN + 2;
    ready_t = acc + FIFO_OFF + h + tn + 2;
    t_exp = acc + FIFO_OFF + 2;
    n = (c.size() < nbytes) ? c.size() : nbytes;
    for (int k = 0; k < n; k++) begin
      if (k > 0) t_exp = t_exp + gap;
      if (k == fd && t_exp < ready_t) t_exp = ready_t;
      check_eq($sformatf("time%0d_%0d", i, k), c[k], t_exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (resp_busy != 2'b00 && k < 2000);
    check_eq("idle", 32'(resp_busy), 32'd0);
  endtask

  task automatic run_line(input logic [1:0] t, input logic [7:0] v, input int mode);
    int acc;
    bq_t e0, e1;
    txm = mode;
    clear_caps();
    @(negedge clk);
    req_valid = 1'b1; req_type = t; req_value = v;
    #1;
    check_eq("req_ready", 32'(req_ready), 32'd3);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    e0 = model_line(t, v, 1'b1);
    e1 = model_line(t, v, 1'b0);
    compare_bytes(0, e0);
    compare_bytes(1, e1);
    compare_timing(0, t, v, mode, acc, e0.size());
    compare_timing(1, t, v, mode, acc, e1.size());
  endtask

  initial begin
    int nacc, ndrop, k;
    bq_t e0, e1, tmp;
    rst_n = 1'b0; req_valid = 1'b0; req_type = 2'd0; req_value = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data[0]), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd3);
    check_eq("rst_resp_busy", 32'(resp_busy), 32'd0);
    check_eq("rst_drop_flag", 32'(drop_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_line(2'd0, 8'h00, 0);
    run_line(2'd2, 8'h80, 0);
    run_line(2'd2, 8'h00, 0);
    run_line(2'd2, 8'h07, 0);
    run_line(2'd1, 8'd255, 0);
    run_line(2'd1, 8'd5, 0);
    run_line(2'd3, 8'h5A, 1);
    run_line(2'd0, 8'h00, 1);
    run_line(2'd1, 8'd12, 1);
    run_line(2'd2, 8'h9D, 1);
    run_line(2'd2, 8'd199, 1);

    for (int r = 0; r < 24; r++)
      run_line(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 1)));

    // Six requests on consecutive cycles.
    txm = 1; clear_caps(); nacc = 0; ndrop = 0;
    e0.delete(); e1.delete();
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      req_valid = 1'b1; req_type = 2'($urandom_range(0, 3)); req_value = 8'($urandom);
      #1;
      if (req_ready[0]) begin
        nacc++;
        tmp = model_line(req_type, req_value, 1'b1); foreach (tmp[m]) e0.push_back(tmp[m]);
        tmp = model_line(req_type, req_value, 1'b0); foreach (tmp[m]) e1.push_back(tmp[m]);
      end
      if (drop_flag[0]) ndrop++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
`ifdef RESP_FIFO_EN
    check_eq("b2b_accepted", 32'(nacc == 4 || nacc == 5), 32'd1);
    check_eq("b2b_dropped", ndrop, 6 - nacc);
`else
    check_eq("b2b_accepted", nacc, 32'd1);
    check_eq("b2b_dropped", ndrop, 32'd5);
`endif
    compare_bytes(0, e0);
    compare_bytes(1, e1);

    // Reset in the middle of "ERR 12".
    txm = 0; clear_caps();
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'd1; req_value = 8'd12;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (cap_d0.size() < 3 && k < 500) begin @(negedge clk); #1; k++; end
    check_eq("mid_bytes", cap_d0.size(), 32'd3);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_eq("mid_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("mid_resp_busy", 32'(resp_busy), 32'd0);
    check_eq("mid_tx_data", 32'(tx_data[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (tx_busy != 2'b00 && k < 100) begin @(negedge clk); #1; k++; end
    check_eq("after_rst_bytes0", cap_d0.size(), 32'd3);
    check_eq("after_rst_bytes1", cap_d1.size(), 32'd3);
    run_line(2'd0, 8'h00, 0);

    check_eq("no_b2b_0", b2b[0], 32'd0);
    check_eq("no_b2b_1", b2b[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
